// File: rtl/sram_read_arbiter.sv
// -----------------------------------------------------------------------------
// sram_read_arbiter
//
// Round-robin arbiter that shares the single read port of a synchronous SRAM
// between NUM_REQ requesters. Each cycle at most one requester is granted.
// The granted requester's address goes to the SRAM read port in that cycle.
// The read data comes back one cycle later, together with a one-hot valid
// strobe that identifies the requester that owns it. The SRAM write port is
// not handled by this block.
//
// Optional feature macro: SRAM_ARB_LOCK_EN
//   When it is defined, a requester that is granted while holding lock[i]=1
//   keeps exclusive ownership of the port for as long as it holds both req[i]
//   and lock[i]. When it is not defined, the lock port is accepted but ignored,
//   and no lock state is built.
//
// Ports:
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   req       in   [NUM_REQ]             per-requester read request
//   req_addr  in   [NUM_REQ*ADDR_WIDTH]  packed addresses, requester i at
//                                        [i*ADDR_WIDTH +: ADDR_WIDTH]
//   lock      in   [NUM_REQ]             per-requester burst lock
//   gnt       out  [NUM_REQ]             one-hot grant, combinational
//   rvalid    out  [NUM_REQ]             one-hot read-data valid, registered
//   rdat_out  out  [DATA_WIDTH]          read data, shared by all requesters
//   ren       out                        SRAM read enable
//   addr      out  [ADDR_WIDTH]          SRAM read address
//   rdat      in   [DATA_WIDTH]          SRAM read data, one cycle after ren
// -----------------------------------------------------------------------------
module sram_read_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdat_out,
  output logic                          ren,
  output logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         rdat
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;      // requester that has priority this cycle
  logic             any_gnt;  // a transfer is issued this cycle
  logic [PTR_W-1:0] gnt_idx;  // index of the granted requester
  logic             lk_hold;  // a lock owner keeps the port this cycle

`ifdef SRAM_ARB_LOCK_EN
  logic             lk_act;
  logic [PTR_W-1:0] lk_own;

  // The lock holds only while its owner still asserts both req and lock. In
  // the first cycle either one is low, normal arbitration takes over.
  assign lk_hold = lk_act & req[lk_own] & lock[lk_own];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lk_hold     = 1'b0;
`endif

  // Round-robin scan that starts at ptr and wraps modulo NUM_REQ.
  // NOTE: every signal assigned in an always_comb block gets a default value
  // first. That way no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    any_gnt = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_gnt && req[idx]) begin
        any_gnt = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
`ifdef SRAM_ARB_LOCK_EN
    if (lk_hold) begin
      any_gnt = 1'b1;
      gnt_idx = lk_own;
    end
`endif
    // Grant outputs stay low while reset is asserted, whatever req does.
    if (!n_rst) begin
      any_gnt = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign ren      = any_gnt;
  assign addr     = any_gnt ? req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign rdat_out = rdat;

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their inputs from the same edge, and the result does not
  // depend on the order in which the simulator evaluates the blocks.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr    <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= gnt;
      // A grant that continues a lock does not move ptr. The grant that
      // starts the lock already set ptr to lk_own+1.
      if (any_gnt && !lk_hold) begin
        ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  // Lock ownership follows every transfer. A locked grant keeps the lock
  // alive. A grant without lock, or no grant at all, releases it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lk_act <= 1'b0;
      lk_own <= '0;
    end else begin
      lk_act <= any_gnt & lock[gnt_idx];
      if (any_gnt && lock[gnt_idx]) begin
        lk_own <= gnt_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_read_arbiter
//
// Directed testbench for sram_read_arbiter with NUM_REQ=3 and 8-bit address
// and data. A small synchronous SRAM model drives rdat one cycle after ren.
// Inputs change 1 ns after the rising edge. Combinational outputs are checked
// 1 ns after that, and registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sram_read_arbiter;

  localparam int NUM_REQ = 3;
  localparam int AW      = 8;
  localparam int DW      = 8;

  logic                  clk;
  logic                  n_rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DW-1:0]         rdat_out;
  logic                  ren;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         rdat;

  logic [DW-1:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  sram_read_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .req     (req),
    .req_addr(req_addr),
    .lock    (lock),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdat_out(rdat_out),
    .ren     (ren),
    .addr    (addr),
    .rdat    (rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM read port
  initial rdat = '0;
  always @(posedge clk) begin
    if (ren) rdat <= mem[addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    n_rst    = 1'b0;
    req      = 3'b111;
    req_addr = {8'h30, 8'h20, 8'h10};
    lock     = '0;
    step();
    step();
    #1;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (ren !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", ren); end
    checks++; if (addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", addr); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt !== exp_seq[i]) begin
        failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]);
      end
      step();
      checks++;
      if (rvalid !== exp_seq[i]) begin
        failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, rvalid, exp_seq[i]);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_read_data();
    mem[5] = 8'hA5;
    mem[9] = 8'h3C;
    req_addr = {8'd9, 8'd5, 8'd0};
    req      = 3'b010;
    #1;
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rd_gnt1 got=%b exp=010", gnt); end
    checks++; if (ren !== 1'b1) begin failures++; $display("FAIL rd_ren1 got=%b exp=1", ren); end
    checks++; if (addr !== 8'd5) begin failures++; $display("FAIL rd_addr1 got=%h exp=05", addr); end
    step();
    checks++; if (rvalid !== 3'b010) begin failures++; $display("FAIL rd_rvalid1 got=%b exp=010", rvalid); end
    checks++; if (rdat_out !== 8'hA5) begin failures++; $display("FAIL rd_data1 got=%h exp=a5", rdat_out); end
    req = 3'b100;
    #1;
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL rd_gnt2 got=%b exp=100", gnt); end
    checks++; if (addr !== 8'd9) begin failures++; $display("FAIL rd_addr2 got=%h exp=09", addr); end
    step();
    checks++; if (rvalid !== 3'b100) begin failures++; $display("FAIL rd_rvalid2 got=%b exp=100", rvalid); end
    checks++; if (rdat_out !== 8'h3C) begin failures++; $display("FAIL rd_data2 got=%h exp=3c", rdat_out); end
    req = '0;
    #1;
    checks++; if (ren !== 1'b0) begin failures++; $display("FAIL rd_idle_ren got=%b exp=0", ren); end
    checks++; if (addr !== 8'h00) begin failures++; $display("FAIL rd_idle_addr got=%h exp=00", addr); end
    step();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rd_idle_rvalid got=%b exp=000", rvalid); end
  endtask

  task automatic test_single();
    logic [7:0] exp_d;
    for (int k = 0; k < 4; k++) mem[k] = 8'hC0 + 8'(k);
    for (int k = 0; k < 4; k++) begin
      req      = 3'b001;
      req_addr = {8'h00, 8'h00, 8'(k)};
      #1;
      checks++;
      if (gnt !== 3'b001) begin failures++; $display("FAIL single_gnt[%0d] got=%b exp=001", k, gnt); end
      checks++;
      if (addr !== 8'(k)) begin failures++; $display("FAIL single_addr[%0d] got=%h exp=%h", k, addr, 8'(k)); end
      step();
      exp_d = 8'hC0 + 8'(k);
      checks++;
      if (rvalid !== 3'b001) begin failures++; $display("FAIL single_rvalid[%0d] got=%b exp=001", k, rvalid); end
      checks++;
      if (rdat_out !== exp_d) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", k, rdat_out, exp_d); end
    end
    req = '0;
    step();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL single_end_rvalid got=%b exp=000", rvalid); end
  endtask

  task automatic test_wrap();
    req = 3'b010;
    #1;
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL wrap_setup_gnt got=%b exp=010", gnt); end
    step();
    req = 3'b101;
    #1;
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL wrap_gnt1 got=%b exp=100", gnt); end
    step();
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL wrap_gnt2 got=%b exp=001", gnt); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    req      = 3'b010;
    req_addr = {8'h00, 8'h44, 8'h00};
    #1;
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rmid_gnt got=%b exp=010", gnt); end
    #1;
    n_rst = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rmid_gnt_forced got=%b exp=000", gnt); end
    checks++; if (ren !== 1'b0) begin failures++; $display("FAIL rmid_ren_forced got=%b exp=0", ren); end
    step();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rmid_rvalid1 got=%b exp=000", rvalid); end
    req   = '0;
    n_rst = 1'b1;
    step();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rmid_rvalid2 got=%b exp=000", rvalid); end
    req = 3'b111;
    #1;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rmid_ptr_gnt got=%b exp=001", gnt); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_lock();
`ifdef SRAM_ARB_LOCK_EN
    logic [2:0] exp_seq [3] = '{3'b001, 3'b001, 3'b001};
    logic [2:0] exp_after   = 3'b010;
`else
    logic [2:0] exp_seq [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] exp_after   = 3'b001;
`endif
    // Make requester 0 first in round-robin order (ptr=0).
    req = 3'b100;
    step();
    req  = 3'b111;
    lock = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (gnt !== exp_seq[i]) begin failures++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]); end
      step();
      checks++;
      if (rvalid !== exp_seq[i]) begin failures++; $display("FAIL lock_rvalid[%0d] got=%b exp=%b", i, rvalid, exp_seq[i]); end
    end
    lock = 3'b000;
    #1;
    checks++;
    if (gnt !== exp_after) begin failures++; $display("FAIL lock_release_gnt got=%b exp=%b", gnt, exp_after); end
    step();
    req = '0;
    step();
  endtask

  initial begin
    n_rst    = 1'b0;
    req      = '0;
    req_addr = '0;
    lock     = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    test_reset();
    test_read_data();
    test_single();
    test_wrap();
    test_reset_mid();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
